// File: rtl/chu_spi_pkg.sv
// chu_spi_pkg: shared FSM state encoding, slot register addresses and ctrl bit positions
// for the chu_spi_core MMIO SPI master.
`default_nettype none

package chu_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    P0    = 2'd2,
    P1    = 2'd3
  } spi_state_e;

  localparam logic [4:0] RX_STATUS = 5'd0;
  localparam logic [4:0] SS        = 5'd1;
  localparam logic [4:0] CTRL      = 5'd2;
  localparam logic [4:0] TX        = 5'd3;

  localparam int DVSR_W        = 16;
  localparam int CTRL_CPOL_BIT = 16;
  localparam int CTRL_CPHA_BIT = 17;
  localparam int CTRL_LOOP_BIT = 18;

endpackage

`default_nettype wire

// File: rtl/chu_spi_engine.sv
// chu_spi_engine: single-byte SPI shift engine (FSM, phase/bit counters, tx/rx shifters).
// Rev 1.0
`default_nettype none

module chu_spi_engine
  import chu_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        tx_byte_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              rx_in_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              ready_o,
  output logic [7:0]        rx_data_o
);

  spi_state_e        state_q, state_d;
  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              phase_last;

  // Counter stops at the shadow divisor, so dvsr=0xFFFF never wraps mid-phase.
  assign phase_last = (cnt_q == dvsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvsr_q    <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvsr_q    <= dvsr_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvsr_d    = dvsr_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tx_d    = tx_byte_i;
          cnt_d   = '0;
          bit_d   = '0;
          dvsr_d  = dvsr_i;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          state_d = cpha_i ? DELAY : P0;
        end
      end
      DELAY: begin
        if (phase_last) begin
          cnt_d   = '0;
          state_d = P0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      P0: begin
        if (phase_last) begin
          rx_d    = {rx_q[6:0], rx_in_i};
          cnt_d   = '0;
          state_d = P1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      P1: begin
        if (phase_last) begin
          cnt_d = '0;
          tx_d  = {tx_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            rx_data_d = rx_q;
            state_d   = IDLE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = P0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle clock tracks the live cpol so a mode change shows on the pin before the next start.
  always_comb begin
    ready_o   = (state_q == IDLE);
    mosi_o    = tx_q[7];
    rx_data_o = rx_data_q;
    case (state_q)
      IDLE:    sclk_o = cpol_i;
      P0:      sclk_o = cpol_q ^ cpha_q;
      P1:      sclk_o = cpol_q ^ ~cpha_q;
      default: sclk_o = cpol_q;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/chu_spi_core.sv
// chu_spi_core: FPro MMIO slot wrapper for a single-byte SPI master (registers, decode, read mux).
// Optional build macro SPI_LOOPBACK_EN adds ctrl bit 18 internal mosi->rx loopback. Rev 1.0
`default_nettype none

module chu_spi_core
  import chu_spi_pkg::*;
#(
  parameter int          S        = 1,
  parameter int unsigned DVSR_RST = 199
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n
);

  logic [S-1:0]      ss_n_q;
  logic [DVSR_W-1:0] dvsr_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              wr_en;
  logic              w_ready;
  logic              w_mosi;
  logic              w_rx_in;
  logic [7:0]        w_rx_data;
  logic              unused_ok;

  assign wr_en     = cs & write;
  assign unused_ok = ^{read, wr_data[31:18]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_n_q <= '1;
      dvsr_q <= DVSR_W'(DVSR_RST);
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else if (wr_en) begin
      if (addr == SS) begin
        ss_n_q <= wr_data[S-1:0];
      end
      if (addr == CTRL) begin
        dvsr_q <= wr_data[DVSR_W-1:0];
        cpol_q <= wr_data[CTRL_CPOL_BIT];
        cpha_q <= wr_data[CTRL_CPHA_BIT];
      end
    end
  end

`ifdef SPI_LOOPBACK_EN
  logic loop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loop_q <= 1'b0;
    end else if (wr_en && (addr == CTRL)) begin
      loop_q <= wr_data[CTRL_LOOP_BIT];
    end
  end

  assign w_rx_in = loop_q ? w_mosi : spi_miso;
`else
  assign w_rx_in = spi_miso;
`endif

  chu_spi_engine u_engine (
    .clk       (clk),
    .rst_n     (reset),
    .start_i   (wr_en && (addr == TX)),
    .tx_byte_i (wr_data[7:0]),
    .dvsr_i    (dvsr_q),
    .cpol_i    (cpol_q),
    .cpha_i    (cpha_q),
    .rx_in_i   (w_rx_in),
    .sclk_o    (spi_sclk),
    .mosi_o    (w_mosi),
    .ready_o   (w_ready),
    .rx_data_o (w_rx_data)
  );

  assign spi_mosi = w_mosi;
  assign spi_ss_n = ss_n_q;

  always_comb begin
    rd_data = '0;
    if (addr == RX_STATUS) begin
      rd_data = {23'b0, w_ready, w_rx_data};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chu_spi_core.sv
// tb_chu_spi_core: directed-vector bench for chu_spi_core with a simple mode-0/3 SPI slave model.
`default_nettype none

module tb_chu_spi_core;

  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cs = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [4:0]   addr = 5'd0;
  logic [31:0]  wr_data = 32'd0;
  logic [31:0]  rd_data;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_miso;
  logic [S-1:0] spi_ss_n;

  int n_vec = 0;
  int n_err = 0;

  chu_spi_core #(.S(S), .DVSR_RST(199)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  always #5 clk = ~clk;

  // Slave model on ss_n[0]: samples mosi on rising sclk, advances its miso bit on falling sclk.
  logic [7:0] slave_rx = 8'd0;
  logic [7:0] slave_byte = 8'd0;
  logic       miso_zero = 1'b0;
  int         fall_cnt = 0;
  int         fall_base = 0;
  int         k;

  always @(posedge spi_sclk) if (spi_ss_n[0] == 1'b0) slave_rx <= {slave_rx[6:0], spi_mosi};
  always @(negedge spi_sclk) if (spi_ss_n[0] == 1'b0) fall_cnt <= fall_cnt + 1;

  assign k        = fall_cnt - fall_base;
  assign spi_miso = (miso_zero || k < 0 || k > 7) ? 1'b0 : slave_byte[3'(7 - k)];

  // Ready-low cycle and pulse totals, sampled mid-cycle.
  int   low_total = 0;
  int   pulse_total = 0;
  logic prev_rdy = 1'b1;
  logic tb_ready;
  assign tb_ready = dut.w_ready;

  always @(negedge clk) begin
    if (!tb_ready) low_total <= low_total + 1;
    if (prev_rdy && !tb_ready) pulse_total <= pulse_total + 1;
    prev_rdy <= tb_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
    #1;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (rd_data[8] !== 1'b1 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic setup(input logic [31:0] ctrl, input logic [7:0] sbyte);
    bus_wr(5'd1, 32'h3);
    bus_wr(5'd2, ctrl);
    bus_wr(5'd1, 32'h2);
    slave_byte = sbyte;
    fall_base  = fall_cnt;
    #1;
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input int exp_len);
    int cyc;
    bus_wr(5'd3, {24'd0, b});
    check({tag, "_ready_low"}, {31'd0, rd_data[8]}, 32'd0);
    check({tag, "_mosi_b7"}, {31'd0, spi_mosi}, {31'd0, b[7]});
    wait_ready(cyc);
    check({tag, "_done"}, {31'd0, rd_data[8]}, 32'd1);
    check({tag, "_len"}, cyc, exp_len);
  endtask

  initial begin
    int l0, p0, cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_rd0", rd_data, 32'h0000_0100);
    check("rst_ss_n", {30'd0, spi_ss_n}, 32'h3);
    check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd0);

    // Mode 0, dvsr=1, send 0xA5 while slave returns 0x3C
    setup(32'h0000_0001, 8'h3C);
    xfer("m0", 8'hA5, 32);
    check("m0_slave_rx", {24'd0, slave_rx}, 32'hA5);
    check("m0_rd0", rd_data, 32'h0000_013C);

    // Mode 3, dvsr=0, send 0x81
    setup(32'h0003_0000, 8'h00);
    check("m3_sclk_idle", {31'd0, spi_sclk}, 32'd1);
    xfer("m3", 8'h81, 17);
    check("m3_slave_rx", {24'd0, slave_rx}, 32'h81);
    check("m3_sclk_after", {31'd0, spi_sclk}, 32'd1);

    // Busy start write must be dropped
    setup(32'h0000_0001, 8'h00);
    l0 = low_total;
    p0 = pulse_total;
    bus_wr(5'd3, 32'h12);
    repeat (5) @(posedge clk);
    #1;
    bus_wr(5'd3, 32'hFF);
    wait_ready(cyc);
    repeat (40) @(posedge clk);
    #1;
    check("busy_ready", {31'd0, rd_data[8]}, 32'd1);
    check("busy_low_cycles", low_total - l0, 32);
    check("busy_pulses", pulse_total - p0, 1);
    check("busy_slave_rx", {24'd0, slave_rx}, 32'h12);

    // Loopback bit with miso held low
    miso_zero = 1'b1;
    setup(32'h0004_0001, 8'h00);
    xfer("loop", 8'h5A, 32);
`ifdef SPI_LOOPBACK_EN
    check("loop_rd0", rd_data, 32'h0000_015A);
`else
    check("loop_rd0", rd_data, 32'h0000_0100);
`endif
    miso_zero = 1'b0;

    // Reset asserted mid-byte (around bit 4)
    setup(32'h0000_0001, 8'hFF);
    bus_wr(5'd3, 32'hC3);
    repeat (17) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, rd_data[8]}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_ss_n", {30'd0, spi_ss_n}, 32'h3);
    check("mid_rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check("mid_rst_rd0", rd_data, 32'h0000_0100);
    check("mid_rst_mosi", {31'd0, spi_mosi}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    setup(32'h0000_0001, 8'h96);
    xfer("post", 8'h69, 32);
    check("post_slave_rx", {24'd0, slave_rx}, 32'h69);
    check("post_rd0", rd_data, 32'h0000_0196);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chu_spi_core.md
# chu_spi_core

MMIO slot core implementing a single-byte SPI master, attached to one slot of the FPro MMIO controller's slot array. Consumes the broadcast slot strobes (cs/read/write/reg address/write data) and returns its register read data on the slot's read-data lane. Provides programmable clock divider, CPOL/CPHA mode, and software-driven slave selects.

## Interface
- `S`, default 1: number of slave-select lines (1..32).
- `DVSR_RST`, default 199: reset value of the half-period divisor.
- `clk`  input  1: system clock.
- `reset`  input  1: asynchronous, active-low reset.
- `cs`  input  1: slot select from MMIO controller.
- `read`  input  1: read strobe (broadcast).
- `write`  input  1: write strobe (broadcast).
- `addr`  input  5: register address within slot.
- `wr_data`  input  32: write data.
- `rd_data`  output  32: read data, combinational.
- `spi_sclk`  output  1: SPI clock.
- `spi_mosi`  output  1: serial data out.
- `spi_miso`  input  1: serial data in.
- `spi_ss_n`  output  S: active-low slave selects.

## Operation
- Register map (write takes effect only when `cs & write`):
  - addr 0 read: `{23'b0, ready, rx_data[7:0]}`. Writes ignored.
  - addr 1 write: `ss_n_reg <= wr_data[S-1:0]`, drives `spi_ss_n` directly, accepted any time.
  - addr 2 write: `dvsr <= wr_data[15:0]`, `cpol <= wr_data[16]`, `cpha <= wr_data[17]`; accepted any time.
  - addr 3 write: start transfer of `wr_data[7:0]` if `ready`=1; ignored while busy.
  - All other addresses read 0; reads have no side effects.
- At start, `dvsr`/`cpol`/`cpha` are copied into shadow registers used for the whole byte; idle `spi_sclk` follows live `cpol`.
- FSM states: IDLE, DELAY, P0, P1. IDLE→DELAY (cpha=1) or →P0 (cpha=0) on accepted start. Each non-IDLE state lasts dvsr+1 clocks (phase counter 0..dvsr). DELAY→P0. P0→P1. P1→P0 if bit count <7 else →IDLE.
- `spi_sclk` = cpol ^ (cpha ? state==P0 : state==P1); equals cpol in IDLE and DELAY.
- MSB first. `spi_mosi` = shift-register bit 7. `spi_miso` sampled into rx shift at final cycle of each P0; tx shifts left at final cycle of each P1.
- Reset values: `spi_ss_n` all ones, `spi_sclk` 0, `spi_mosi` 0, ready 1, rx_data 0x00, dvsr DVSR_RST, cpol 0, cpha 0, state IDLE.

## Timing
- Start write at clock edge t → at t+1: ready=0, `spi_mosi`=bit 7, state P0/DELAY, counter 0.
- Transfer length: 16·(dvsr+1) clocks (cpha=0), 17·(dvsr+1) (cpha=1), measured from t+1 until ready returns to 1.
- rx_data holds final byte in the same cycle ready rises; rx_data only updates at transfer end (internal shift register separate).
- dvsr=0: one-clock phases, legal. dvsr=0xFFFF: 65536-clock phases, counter must not overflow.
- Simultaneous start write and ctrl write impossible (one addr per cycle); ctrl write during transfer affects only next byte.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous), partial byte discarded.

## Configuration
- `SPI_LOOPBACK_EN` defined: ctrl bit 18 (`loop`, reset 0) implemented; when set, rx samples `spi_mosi` instead of `spi_miso`; `spi_sclk`/`spi_mosi` still drive pins.
- Undefined: bit 18 ignored, no loop register, rx always samples `spi_miso`.

## Structure
- Package `chu_spi_pkg`: FSM state enum (IDLE, DELAY, P0, P1), register address constants (RX_STATUS=0, SS=1, CTRL=2, TX=3), ctrl bit positions.
- Sub-module `chu_spi_engine`: FSM, phase counter, bit counter, shift registers; `chu_spi_core` holds register file, address decode, read mux.

## Test plan
- Reset release → read addr 0 = 0x0000_0100; `spi_ss_n` all ones; `spi_sclk`=0.
- Mode 0, dvsr=1, write 0xA5 to addr 3, slave model returns 0x3C → mosi sequence 1,0,1,0,0,1,0,1; ready low exactly 32 clocks; read addr 0 = 0x0000_013C.
- Mode 3 (cpol=1,cpha=1), dvsr=0, send 0x81 → sclk idles 1, busy 17 clocks, slave sees 0x81 sampled on rising edges.
- Busy write of 0xFF to addr 3 mid-transfer of 0x12 → ignored; slave receives only 0x12, single ready pulse-low.
- `SPI_LOOPBACK_EN` build, ctrl bit 18=1, miso tied 0, send 0x5A → rx 0x5A; without macro same stimulus → rx 0x00.
- Assert reset during bit 4 → ss_n all ones, sclk 0, ready 1 immediately; next transfer after release completes normally.
